qacc_lanes: RTL

Multi-lane, streaming sign-magnitude fixed-point accumulator for the convolution datapath. Each lane sums a packet of Q-format sign-magnitude operands, one beat per cycle, using the same sign-magnitude add rules as the combinational fixed-point adder. Unlike that adder, it saturates on overflow instead of wrapping, never emits negative zero, and delivers one result per lane per packet over a valid/ready handshake. It sits between the MAC array and the activation/requantise stage and reduces partial products over a kernel window.

---
 rtl/qacc_lanes.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/qacc_lanes.sv
// qacc_lanes: multi-lane streaming sign-magnitude accumulator.
// Each lane reduces one packet of sign-magnitude beats with saturating
// add, and the block hands one result per packet downstream over valid/ready.
module qacc_lanes #(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   out_data,
    output logic [LANES-1:0]     out_ovf,
    output logic [CNT_W-1:0]     out_beats
);

    // Q only sets how software reads the words; the datapath ignores it.
    // A Q that leaves no room in the magnitude field refuses to elaborate.
    generate
        if (Q > N - 1) begin : g_q_out_of_range
            q_exceeds_magnitude_width u_bad ();
        end
    endgenerate

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_reg;
    logic               out_valid_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   out_beats_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               accept;
    logic               accept_last;

    // Saturating sign-magnitude add; result is {overflow, sign, magnitude}.
    // Negative zero on either input is read as +0 and is never produced.
    function automatic logic [N:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] am;
        logic [N-2:0] bm;
        logic [N-2:0] mag;
        logic [N-1:0] msum;
        logic         as;
        logic         bs;
        logic         sgn;
        logic         ovf;
        am   = a[N-2:0];
        bm   = b[N-2:0];
        as   = a[N-1] && (am != '0);
        bs   = b[N-1] && (bm != '0);
        mag  = '0;
        msum = '0;
        sgn  = 1'b0;
        ovf  = 1'b0;
        if (as == bs) begin
            msum = {1'b0, am} + {1'b0, bm};
            if (msum[N-1]) begin
                mag = '1;
                ovf = 1'b1;
            end else begin
                mag = msum[N-2:0];
            end
            sgn = as;
        end else if (am >= bm) begin
            mag = am - bm;
            sgn = as;
        end else begin
            mag = bm - am;
            sgn = bs;
        end
        if (mag == '0) begin
            sgn = 1'b0;
        end
        return {ovf, sgn, mag};
    endfunction

    assign in_ready    = !out_valid_reg || out_ready;
    assign accept      = in_valid && in_ready;
    assign accept_last = accept && in_last;
    assign cnt_next    = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

    assign out_valid = out_valid_reg;
    assign out_beats = out_beats_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [N-1:0] acc_reg;
            logic [N-1:0] out_data_reg;
            logic         ovf_reg;
            logic         out_ovf_reg;
            logic [N-1:0] sum_next;
            logic         lane_ovf;

            assign {lane_ovf, sum_next} = sat_add(acc_reg, in_data[gi*N +: N]);
            assign out_data[gi*N +: N]  = out_data_reg;
            assign out_ovf[gi]          = out_ovf_reg;

            // Lane accumulator: fold accepted beats in, publish and clear on the last beat.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_reg      <= '0;
                    ovf_reg      <= 1'b0;
                    out_data_reg <= '0;
                    out_ovf_reg  <= 1'b0;
                end else if (accept) begin
                    if (in_last) begin
                        out_data_reg <= sum_next;
                        out_ovf_reg  <= ovf_reg | lane_ovf;
                        acc_reg      <= '0;
                        ovf_reg      <= 1'b0;
                    end else begin
                        acc_reg <= sum_next;
                        ovf_reg <= ovf_reg | lane_ovf;
                    end
                end
            end
        end
    endgenerate

    // Output FSM plus shared beat counter; out_valid is a registered copy of FULL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            out_beats_reg <= '0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    out_beats_reg <= cnt_next;
                    cnt_reg       <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
            case (state_reg)
                EMPTY: begin
                    if (accept_last) begin
                        state_reg     <= FULL;
                        out_valid_reg <= 1'b1;
                    end
                end
                FULL: begin
                    if (!accept_last && out_ready) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
